// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter
//   Two-port arbiter that merges the CPU instruction-side and data-side bus
//   requests onto one shared Wishbone-style master port.
//
//   Ports
//     clk_i, rst_i                 clock, async active-high reset
//     i_stb_i, i_adr_i             instruction request (held until i_ack_o)
//     i_dat_o, i_ack_o             instruction read data / completion pulse
//     d_stb_i, d_we_i, d_sel_i,    data request (held until d_ack_o)
//     d_adr_i, d_dat_i
//     d_dat_o, d_ack_o             data read data / completion pulse
//     bus_cyc_o .. bus_dat_o       registered shared-bus master outputs
//     bus_dat_i, bus_ack_i         shared-bus read data / acknowledge
//     arb_err_o                    timeout abort pulse
//
//   Configuration macro: ARB_TIMEOUT_EN
//     When defined, a transfer that sees no bus_ack_i for TIMEOUT_CYCLES
//     cycles in a grant state is aborted: the granted side gets an ack with
//     zero data and arb_err_o pulses. When undefined, grants wait forever
//     and arb_err_o is tied low.
module cpu_bus_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            i_stb_i,
    input  logic [AW-1:0]   i_adr_i,
    output logic [DW-1:0]   i_dat_o,
    output logic            i_ack_o,
    input  logic            d_stb_i,
    input  logic            d_we_i,
    input  logic [DW/8-1:0] d_sel_i,
    input  logic [AW-1:0]   d_adr_i,
    input  logic [DW-1:0]   d_dat_i,
    output logic [DW-1:0]   d_dat_o,
    output logic            d_ack_o,
    output logic            bus_cyc_o,
    output logic            bus_stb_o,
    output logic            bus_we_o,
    output logic [DW/8-1:0] bus_sel_o,
    output logic [AW-1:0]   bus_adr_o,
    output logic [DW-1:0]   bus_dat_o,
    input  logic [DW-1:0]   bus_dat_i,
    input  logic            bus_ack_i,
    output logic            arb_err_o
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("cpu_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t            r_state;
    logic              r_last_d;
    logic              r_bus_cyc;
    logic              r_bus_stb;
    logic              r_bus_we;
    logic [DW/8-1:0]   r_bus_sel;
    logic [AW-1:0]     r_bus_adr;
    logic [DW-1:0]     r_bus_dat;

    logic              w_gnt_i;
    logic              w_gnt_d;
    logic              w_tmo;    // timeout reached this cycle (grant states only)
    logic              w_abort;  // timeout with no real ack: forced completion
    logic              w_done;   // transfer ends on the coming edge
    logic              w_pick_d; // IDLE arbitration result

    assign w_gnt_i  = (r_state == GNT_I);
    assign w_gnt_d  = (r_state == GNT_D);
    // A real ack in the same cycle as the timeout wins, so abort needs ~ack.
    assign w_abort  = w_tmo & ~bus_ack_i;
    assign w_done   = bus_ack_i | w_tmo;
    // Both requesting: alternate away from the last granted side.
    assign w_pick_d = d_stb_i & ~(i_stb_i & r_last_d);

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;

    // r_cnt holds the number of grant cycles already elapsed, so the
    // TIMEOUT_CYCLES-th grant cycle sees TIMEOUT_CYCLES-1.
    assign w_tmo = (w_gnt_i | w_gnt_d) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_cnt <= '0;
        end else if (!w_done) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_last_d  <= 1'b0;
            r_bus_cyc <= 1'b0;
            r_bus_stb <= 1'b0;
            r_bus_we  <= 1'b0;
            r_bus_sel <= '0;
            r_bus_adr <= '0;
            r_bus_dat <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Stray bus_ack_i here is ignored by construction.
                    if (i_stb_i || d_stb_i) begin
                        r_bus_cyc <= 1'b1;
                        r_bus_stb <= 1'b1;
                        if (w_pick_d) begin
                            r_state   <= GNT_D;
                            r_bus_we  <= d_we_i;
                            r_bus_sel <= d_sel_i;
                            r_bus_adr <= d_adr_i;
                            r_bus_dat <= d_dat_i;
                        end else begin
                            r_state   <= GNT_I;
                            r_bus_we  <= 1'b0;
                            r_bus_sel <= '1;
                            r_bus_adr <= i_adr_i;
                            r_bus_dat <= '0;
                        end
                    end
                end
                GNT_I, GNT_D: begin
                    // Requester inputs are not looked at until completion.
                    if (w_done) begin
                        r_state   <= IDLE;
                        r_last_d  <= w_gnt_d;
                        r_bus_cyc <= 1'b0;
                        r_bus_stb <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_bus_cyc <= 1'b0;
                    r_bus_stb <= 1'b0;
                end
            endcase
        end
    end

    assign bus_cyc_o = r_bus_cyc;
    assign bus_stb_o = r_bus_stb;
    assign bus_we_o  = r_bus_we;
    assign bus_sel_o = r_bus_sel;
    assign bus_adr_o = r_bus_adr;
    assign bus_dat_o = r_bus_dat;

    assign i_ack_o   = w_gnt_i & w_done;
    assign d_ack_o   = w_gnt_d & w_done;
    assign i_dat_o   = (w_gnt_i && !w_abort) ? bus_dat_i : '0;
    assign d_dat_o   = (w_gnt_d && !w_abort) ? bus_dat_i : '0;
    assign arb_err_o = w_abort;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Self-checking bench for cpu_bus_arbiter: directed scenarios followed by
// randomized requesters and slave, all checked against a transaction-level
// reference model of the arbitration rules.
module tb_cpu_bus_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_stb_i;
    logic [AW-1:0] i_adr_i;
    logic [DW-1:0] i_dat_o;
    logic          i_ack_o;
    logic          d_stb_i;
    logic          d_we_i;
    logic [SW-1:0] d_sel_i;
    logic [AW-1:0] d_adr_i;
    logic [DW-1:0] d_dat_i;
    logic [DW-1:0] d_dat_o;
    logic          d_ack_o;
    logic          bus_cyc_o;
    logic          bus_stb_o;
    logic          bus_we_o;
    logic [SW-1:0] bus_sel_o;
    logic [AW-1:0] bus_adr_o;
    logic [DW-1:0] bus_dat_o;
    logic [DW-1:0] bus_dat_i;
    logic          bus_ack_i;
    logic          arb_err_o;

    always #5 clk = ~clk;

    cpu_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_i(rst),
        .i_stb_i(i_stb_i), .i_adr_i(i_adr_i), .i_dat_o(i_dat_o), .i_ack_o(i_ack_o),
        .d_stb_i(d_stb_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i), .d_adr_i(d_adr_i),
        .d_dat_i(d_dat_i), .d_dat_o(d_dat_o), .d_ack_o(d_ack_o),
        .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
        .bus_sel_o(bus_sel_o), .bus_adr_o(bus_adr_o), .bus_dat_o(bus_dat_o),
        .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i), .arb_err_o(arb_err_o)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: one outstanding transaction on the shared bus.
    bit            m_busy;
    bit            m_d;       // owner of the current transaction is the data side
    bit            m_last_d;
    logic [AW-1:0] m_adr;
    logic          m_we;
    logic [SW-1:0] m_sel;
    logic [DW-1:0] m_dat;
    int            m_age;     // 1 on the first grant cycle
    bit            e_iack, e_dack;

    int n_iack = 0, n_dack = 0, n_aerr = 0;
    bit gq[$];                // DUT-observed completion order, 1 = data side

    task automatic model_reset();
        m_busy = 0; m_d = 0; m_last_d = 0; m_age = 0;
    endtask

    // Called at a falling edge with inputs already applied: checks this
    // cycle's outputs, advances the model across the next rising edge and
    // returns at the following falling edge.
    task automatic step();
        bit tmo, done, abort;
        logic [DW-1:0] ei, ed;
        #1;
        tmo = 0;
`ifdef ARB_TIMEOUT_EN
        tmo = m_busy && (m_age == TMO);
`endif
        done   = m_busy && (bus_ack_i || tmo);
        abort  = tmo && !bus_ack_i;
        e_iack = done && !m_d;
        e_dack = done && m_d;
        ei = (m_busy && !m_d && !abort) ? bus_dat_i : '0;
        ed = (m_busy &&  m_d && !abort) ? bus_dat_i : '0;
        chk("bus_cyc", bus_cyc_o, m_busy);
        chk("bus_stb", bus_stb_o, m_busy);
        if (m_busy) begin
            chk("bus_adr", bus_adr_o, m_adr);
            chk("bus_we",  bus_we_o,  m_we);
            chk("bus_sel", bus_sel_o, m_sel);
            chk("bus_dat", bus_dat_o, m_dat);
        end
        chk("i_ack",   i_ack_o,   e_iack);
        chk("d_ack",   d_ack_o,   e_dack);
        chk("i_dat",   i_dat_o,   ei);
        chk("d_dat",   d_dat_o,   ed);
        chk("arb_err", arb_err_o, abort);
        if (i_ack_o)   begin n_iack++; gq.push_back(1'b0); end
        if (d_ack_o)   begin n_dack++; gq.push_back(1'b1); end
        if (arb_err_o) n_aerr++;
        if (m_busy) begin
            if (done) begin m_busy = 0; m_last_d = m_d; end
            else m_age++;
        end else if (i_stb_i || d_stb_i) begin
            m_d    = d_stb_i && !(i_stb_i && m_last_d);
            m_busy = 1;
            m_age  = 1;
            if (m_d) begin
                m_adr = d_adr_i; m_we = d_we_i; m_sel = d_sel_i; m_dat = d_dat_i;
            end else begin
                m_adr = i_adr_i; m_we = 1'b0; m_sel = '1; m_dat = '0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bit exp_order [4];
        int base_i, base_d;
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
        rst = 1'b1;
        i_stb_i = 0; i_adr_i = '0; d_stb_i = 0; d_we_i = 0; d_sel_i = '0;
        d_adr_i = '0; d_dat_i = '0; bus_dat_i = 32'hDEAD_BEEF; bus_ack_i = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cyc", bus_cyc_o, 0);
        chk("rst_stb", bus_stb_o, 0);
        chk("rst_we",  bus_we_o,  0);
        chk("rst_sel", bus_sel_o, 0);
        chk("rst_adr", bus_adr_o, 0);
        chk("rst_dat", bus_dat_o, 0);
        chk("rst_err", arb_err_o, 0);
        chk("rst_iack", i_ack_o, 0);
        chk("rst_dack", d_ack_o, 0);
        @(negedge clk);
        rst = 1'b0; bus_ack_i = 1'b0;

        // Data write, ack on the second grant cycle.
        d_stb_i = 1; d_we_i = 1; d_adr_i = 32'h100; d_dat_i = 32'hCAFE_F00D; d_sel_i = 4'hF;
        step();
        #1;
        chk("t1_stb_rise", bus_stb_o, 1);
        chk("t1_adr", bus_adr_o, 32'h100);
        chk("t1_dat", bus_dat_o, 32'hCAFE_F00D);
        step();
        bus_ack_i = 1;
        step();
        d_stb_i = 0; bus_ack_i = 0;
        step(); step();
        chk("t1_dack_pulses", n_dack, 1);
        chk("t1_iack_pulses", n_iack, 0);

        // Instruction fetch, immediate ack.
        i_stb_i = 1; i_adr_i = 32'h400; bus_dat_i = 32'h1234_5678;
        step();
        #1;
        chk("t2_we",  bus_we_o,  0);
        chk("t2_sel", bus_sel_o, 4'hF);
        bus_ack_i = 1;
        #1;
        chk("t2_iack", i_ack_o, 1);
        chk("t2_idat", i_dat_o, 32'h1234_5678);
        step();
        i_stb_i = 0; bus_ack_i = 0;
        step();

        // Both requesting: alternation.
        gq.delete();
        i_stb_i = 1; d_stb_i = 1;
        for (int k = 0; k < 40 && gq.size() < 4; k++) begin
            bus_ack_i = m_busy;
            step();
        end
        i_stb_i = 0; d_stb_i = 0; bus_ack_i = 0;
        chk("t3_grants", gq.size(), 4);
        for (int k = 0; k < 4 && k < gq.size(); k++) chk($sformatf("t3_order%0d", k), gq[k], exp_order[k]);
        step();

        // Stray ack in IDLE, then reset in the middle of a data grant.
        base_i = n_iack; base_d = n_dack;
        bus_ack_i = 1;
        step(); step();
        chk("t4_stray_iack", n_iack, base_i);
        chk("t4_stray_dack", n_dack, base_d);
        bus_ack_i = 0; d_stb_i = 1; d_we_i = 0; d_adr_i = 32'h200;
        step(); step();
        bus_ack_i = 1;
        #2 rst = 1'b1;
        #1;
        chk("t4_rst_cyc", bus_cyc_o, 0);
        chk("t4_rst_stb", bus_stb_o, 0);
        chk("t4_rst_dack", d_ack_o, 0);
        chk("t4_rst_iack", i_ack_o, 0);
        d_stb_i = 0; bus_ack_i = 0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step();

        // No ack at all: timeout abort, or an indefinitely held grant.
        base_d = n_dack;
        d_stb_i = 1; d_dat_i = 32'h55AA_55AA; bus_dat_i = 32'hFFFF_FFFF;
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < TMO + 6; k++) begin
            step();
            if (e_dack) d_stb_i = 0;
        end
        chk("t5_tmo_dack", n_dack, base_d + 1);
        chk("t5_tmo_err",  n_aerr, 1);
`else
        for (int k = 0; k < 110; k++) step();
        chk("t5_hold_cyc", bus_cyc_o, 1);
        chk("t5_no_dack", n_dack, base_d);
        d_stb_i = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
`endif
        d_stb_i = 0;
        step();

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            i_adr_i   = $urandom;
            d_adr_i   = $urandom;
            d_dat_i   = $urandom;
            d_sel_i   = SW'($urandom);
            d_we_i    = 1'($urandom);
            bus_dat_i = $urandom;
            bus_ack_i = ($urandom_range(0, 2) == 0);
            step();
            if (e_iack) i_stb_i = 0;
            else if (!i_stb_i && $urandom_range(0, 3) == 0) i_stb_i = 1;
            if (e_dack) d_stb_i = 0;
            else if (!d_stb_i && $urandom_range(0, 3) == 0) d_stb_i = 1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
